bank_rd_agu: RTL and testbench
==============================

Name: bank_rd_agu

Overview:
- Read-side address generation unit for one 128-bit data bank.
- Walks a two-level nested address pattern (base, inner stride/count, outer stride/count) and issues one bank read per cycle on rd_en/rd_addr/rd_muxcode.
- Delays the issue strobe by the bank's read latency to produce rd_valid/rd_last aligned with the bank's broadcast read word.
- Sits directly upstream of the bank and drives its read port; its consumer samples rdi/rdd/rdc_word when rd_valid is high.

Parameters:
- a, 9, bank address width; all address arithmetic is modulo 2^a.
- RD_LAT, 2, cycles from rd_en/rd_addr sampled to read word valid at bank output; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- base_addr  in  a  first address of the pattern; latched on accepted start.
- i_cnt_m1  in  a  inner loop length minus one (0 means 1 read).
- o_cnt_m1  in  a  outer loop length minus one.
- i_stride  in  a  inner address increment, two's complement, wraps mod 2^a.
- o_stride  in  a  outer base increment, two's complement, wraps mod 2^a.
- muxcode  in  2  read destination code; latched on accepted start.
- hold  in  1  stalls issue when 1; reads already in flight still complete.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on completion.
- rd_en  out  1  bank read enable.
- rd_addr  out  a  bank read address.
- rd_muxcode  out  2  latched muxcode, held stable for the whole command.
- rd_valid  out  1  bank read word valid this cycle.
- rd_last  out  1  qualifies the final rd_valid of the command.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE; busy, done, rd_en, rd_valid, rd_last = 0; rd_addr = 0; rd_muxcode = 0; valid pipeline cleared. In-flight reads are discarded with no done.
- FSM states:
  - IDLE: start=1 at an edge latches all command inputs, sets optr=base_addr, ptr=base_addr, i=0, o=0; next state RUN; busy=1 from the next cycle.
  - RUN: in each cycle with hold=0, rd_en=1 and rd_addr=ptr, then the counters advance:
    - if i<i_cnt_m1: i+=1, ptr+=i_stride.
    - else if o<o_cnt_m1: i=0, o+=1, optr+=o_stride, ptr=optr+o_stride.
    - else: final issue, next state DRAIN.
  - hold=1 in RUN: rd_en=0; ptr and counters frozen. rd_addr holds its last value (don't-care to the bank).
  - DRAIN: rd_en=0. Remain until the final read's rd_valid has occurred.
- rd_valid and rd_last: rd_valid equals rd_en delayed by exactly RD_LAT cycles (shift register). rd_last equals the final-issue flag delayed by RD_LAT cycles.
- done: pulses in the same cycle as rd_valid&rd_last. The next cycle returns to IDLE with busy=0.
- Busy window: busy is 1 from the cycle after the accepted start through the done cycle inclusive.
- Start ordering: a start asserted in the done cycle is ignored. The earliest accepted start is the first cycle with busy=0.
- Latency: start sampled at edge 0 gives first rd_en in cycle 1 with rd_addr=base_addr, and first rd_valid in cycle 1+RD_LAT. With no hold, total reads = (i_cnt_m1+1)*(o_cnt_m1+1) in consecutive cycles.
- Address wrap: all address sums are truncated to a bits; no error is flagged.
- Count extremes: i_cnt_m1=o_cnt_m1=0 gives a single read with rd_last=1 on that read. Maximum counts give 2^(2a) reads; counters never overflow because the compare happens before the increment.
- hold during DRAIN or IDLE: no effect.
- hold asserted in the same cycle as the final issue: suppresses that issue; the final issue happens on the next hold=0 cycle.
- rd_muxcode: never changes while busy=1.

Test Plan:
- Reset mid-run: start base=0, i_cnt_m1=7, o_cnt_m1=0. Drop rst_n after 3 issues -> all outputs 0 immediately, no done, no further rd_valid. Next start is accepted normally.
- Linear burst, RD_LAT=2: start base=0x010, i_cnt_m1=3, o_cnt_m1=0, i_stride=1, muxcode=2 -> rd_addr 0x010..0x013 in cycles 1-4; rd_valid in cycles 3-6; rd_last and done in cycle 6; rd_muxcode=2 throughout; busy in cycles 1-6.
- 2-D pattern: base=0x000, i_cnt_m1=2, i_stride=4, o_cnt_m1=1, o_stride=1 -> addresses 0,4,8,1,5,9; exactly 6 rd_valid; rd_last only on the 6th.
- Wrap and negative stride: base=0x1FE, i_stride=1, i_cnt_m1=3 -> 0x1FE,0x1FF,0x000,0x001. Separately, base=0x002, i_stride=0x1FF (-1), i_cnt_m1=3 -> 2,1,0,0x1FF.
- Hold: same linear burst with hold=1 in cycles 2-3 -> rd_en low in cycles 2-3; addresses still 0x010..0x013 with no skip or duplicate; done moves 2 cycles later (cycle 8). hold=1 in DRAIN leaves done unchanged.
- Single read and start while busy: i_cnt_m1=o_cnt_m1=0 -> one rd_en, rd_valid with rd_last and done at cycle 1+RD_LAT. A start pulsed during busy or in the done cycle -> ignored, no extra rd_en.

Source files
------------

// File: rtl/bank_rd_agu.sv
// Read-side address generator for one 128-bit data bank.
// Walks a base / inner-stride / outer-stride pattern, issues one read per
// cycle, and delays the issue strobe by the bank read latency so that
// rd_valid/rd_last line up with the bank's read word.
module bank_rd_agu #(
    parameter int a      = 9,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [a-1:0] base_addr,
    input  logic [a-1:0] i_cnt_m1,
    input  logic [a-1:0] o_cnt_m1,
    input  logic [a-1:0] i_stride,
    input  logic [a-1:0] o_stride,
    input  logic [1:0]   muxcode,
    input  logic         hold,
    output logic         busy,
    output logic         done,
    output logic         rd_en,
    output logic [a-1:0] rd_addr,
    output logic [1:0]   rd_muxcode,
    output logic         rd_valid,
    output logic         rd_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q;
    logic [a-1:0]      ptr_q;
    logic [a-1:0]      optr_q;
    logic [a-1:0]      i_q;
    logic [a-1:0]      o_q;
    logic [a-1:0]      icnt_q;
    logic [a-1:0]      ocnt_q;
    logic [a-1:0]      istr_q;
    logic [a-1:0]      ostr_q;
    logic [1:0]        mux_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] lst_q;
    logic [RD_LAT-1:0] lst_d;

    logic issue;
    logic i_more;
    logic o_more;
    logic final_issue;

    // Issue strobe and end-of-loop decode for the current pointer.
    always_comb begin
        issue       = (state_q == S_RUN) && !hold;
        i_more      = (i_q < icnt_q);
        o_more      = (o_q < ocnt_q);
        final_issue = issue && !i_more && !o_more;
    end

    // Command FSM and address walk; counters compare before incrementing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            optr_q  <= '0;
            i_q     <= '0;
            o_q     <= '0;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            istr_q  <= '0;
            ostr_q  <= '0;
            mux_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ptr_q   <= base_addr;
                        optr_q  <= base_addr;
                        i_q     <= '0;
                        o_q     <= '0;
                        icnt_q  <= i_cnt_m1;
                        ocnt_q  <= o_cnt_m1;
                        istr_q  <= i_stride;
                        ostr_q  <= o_stride;
                        mux_q   <= muxcode;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (i_more) begin
                            i_q   <= i_q + 1'b1;
                            ptr_q <= ptr_q + istr_q;
                        end else if (o_more) begin
                            i_q    <= '0;
                            o_q    <= o_q + 1'b1;
                            optr_q <= optr_q + ostr_q;
                            ptr_q  <= optr_q + ostr_q;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Next value of the read-latency shift registers (bit 0 = this cycle's issue).
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = issue;
        lst_d[0] = final_issue;
        for (int unsigned k = 1; k < unsigned'(RD_LAT); k++) begin
            vld_d[k] = vld_q[k-1];
            lst_d[k] = lst_q[k-1];
        end
    end

    // Read-latency shift registers; reset discards in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    // Output drive.
    always_comb begin
        busy       = (state_q != S_IDLE);
        rd_en      = issue;
        rd_addr    = ptr_q;
        rd_muxcode = mux_q;
        rd_valid   = vld_q[RD_LAT-1];
        rd_last    = lst_q[RD_LAT-1];
        done       = (state_q == S_DRAIN) && vld_q[RD_LAT-1] && lst_q[RD_LAT-1];
    end

endmodule

// File: tb/tb_bank_rd_agu.sv
// Directed bench for bank_rd_agu: a reference walk of the nested address
// pattern fills an issue queue; a monitor checks every issued address and
// every delayed rd_valid/rd_last/done against it.
module tb_bank_rd_agu;

    localparam int A      = 9;
    localparam int RD_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [A-1:0] base_addr;
    logic [A-1:0] i_cnt_m1;
    logic [A-1:0] o_cnt_m1;
    logic [A-1:0] i_stride;
    logic [A-1:0] o_stride;
    logic [1:0]   muxcode;
    logic         hold;
    logic         busy;
    logic         done;
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [1:0]   rd_muxcode;
    logic         rd_valid;
    logic         rd_last;

    always #5 clk = ~clk;

    bank_rd_agu #(.a(A), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .i_cnt_m1   (i_cnt_m1),
        .o_cnt_m1   (o_cnt_m1),
        .i_stride   (i_stride),
        .o_stride   (o_stride),
        .muxcode    (muxcode),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_muxcode (rd_muxcode),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last)
    );

    typedef struct packed {
        logic [A-1:0] addr;
        logic         last;
    } iss_t;

    typedef struct {
        logic last;
        int   cyc;
    } vexp_t;

    iss_t       iq[$];
    vexp_t      vq[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    int         vcount   = 0;
    int         done_cnt = 0;
    logic [1:0] exp_mux  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference walk: outer base = base + o*o_stride, address = outer base + i*i_stride.
    task automatic gen(input logic [A-1:0] base, input logic [A-1:0] icnt, input logic [A-1:0] ocnt,
                       input logic [A-1:0] istr, input logic [A-1:0] ostr, output int n);
        logic [31:0] s;
        iss_t        e;
        n = 0;
        for (int unsigned o = 0; o <= ocnt; o++) begin
            for (int unsigned i = 0; i <= icnt; i++) begin
                s      = base + o * ostr + i * istr;
                e.addr = s[A-1:0];
                e.last = (o == ocnt) && (i == icnt);
                iq.push_back(e);
                n++;
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        iss_t  e;
        vexp_t v;
        logic  exp_done;
        if (rst_n) begin
            exp_done = rd_valid && (vq.size() > 0) && vq[0].last;
            check("done_align", done, exp_done);
            if (busy) check("rd_muxcode_stable", rd_muxcode, exp_mux);
            if (vq.size() == 0) begin
                check("spurious_rd_valid", rd_valid, 1'b0);
            end else if (rd_valid) begin
                v = vq.pop_front();
                check("rd_last", rd_last, v.last);
                check("rd_valid_cycle", cyc, v.cyc);
                vcount++;
            end
            if (!rd_valid) check("rd_last_idle", rd_last, 1'b0);
            if (iq.size() == 0) begin
                check("spurious_rd_en", rd_en, 1'b0);
            end else if (rd_en) begin
                e = iq.pop_front();
                check("rd_addr", rd_addr, e.addr);
                v.last = e.last;
                v.cyc  = cyc + RD_LAT;
                vq.push_back(v);
            end
            if (done) done_cnt++;
        end
    end

    // Runs one command; hold is high in relative cycles hf..ht, start is
    // re-pulsed in relative cycles sp1/sp2 (0 = never). Cycle 1 is the
    // cycle after the edge that samples the accepted start.
    task automatic run_cmd(input string tag, input logic [A-1:0] base, input logic [A-1:0] icnt,
                           input logic [A-1:0] ocnt, input logic [A-1:0] istr, input logic [A-1:0] ostr,
                           input logic [1:0] mux, input int hf, input int ht, input int sp1,
                           input int sp2, input int exp_done_rel);
        int n;
        int t0;
        int rel;
        bit seen;
        gen(base, icnt, ocnt, istr, ostr, n);
        vcount    = 0;
        exp_mux   = mux;
        base_addr = base;
        i_cnt_m1  = icnt;
        o_cnt_m1  = ocnt;
        i_stride  = istr;
        o_stride  = ostr;
        muxcode   = mux;
        start     = 1'b1;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            rel   = cyc - t0 + 1;
            hold  = (rel >= hf) && (rel <= ht);
            start = (rel == sp1) || (rel == sp2);
            if (rel == 1) check({tag, "_busy_c1"}, busy, 1'b1);
            @(negedge clk);
            if ((rel >= hf) && (rel <= ht)) check({tag, "_rd_en_held"}, rd_en, 1'b0);
            if (done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, rel, exp_done_rel);
                check({tag, "_busy_done"}, busy, 1'b1);
            end
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_issues_left"}, iq.size(), 0);
        check({tag, "_valids_left"}, vq.size(), 0);
        check({tag, "_valid_count"}, vcount, n);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        hold      = 1'b0;
        base_addr = '0;
        i_cnt_m1  = '0;
        o_cnt_m1  = '0;
        i_stride  = '0;
        o_stride  = '0;
        muxcode   = '0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_last", rd_last, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_muxcode", rd_muxcode, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of an 8-read burst, after three issues.
        gen(9'h000, 9'd7, 9'd0, 9'd1, 9'd0, n);
        exp_mux   = 2'd1;
        base_addr = 9'h000;
        i_cnt_m1  = 9'd7;
        o_cnt_m1  = 9'd0;
        i_stride  = 9'd1;
        o_stride  = 9'd0;
        muxcode   = 2'd1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        iq.delete();
        vq.delete();
        d0 = done_cnt;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_rd_valid", rd_valid, 1'b0);
        check("mid_rst_rd_last", rd_last, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_rd_muxcode", rd_muxcode, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_idle", busy, 1'b0);

        run_cmd("linear",   9'h010, 9'd3, 9'd0, 9'd1,   9'd0,   2'd2, 0, 0, 0, 0, 6);
        run_cmd("two_d",    9'h000, 9'd2, 9'd1, 9'd4,   9'd1,   2'd1, 0, 0, 0, 0, 8);
        run_cmd("wrap_up",  9'h1FE, 9'd3, 9'd0, 9'd1,   9'd0,   2'd3, 0, 0, 0, 0, 6);
        run_cmd("neg_str",  9'h002, 9'd3, 9'd0, 9'h1FF, 9'd0,   2'd0, 0, 0, 0, 0, 6);
        run_cmd("hold_run", 9'h010, 9'd3, 9'd0, 9'd1,   9'd0,   2'd2, 2, 3, 0, 0, 8);
        run_cmd("hold_drn", 9'h010, 9'd3, 9'd0, 9'd1,   9'd0,   2'd2, 5, 6, 0, 0, 6);
        run_cmd("hold_fin", 9'h010, 9'd3, 9'd0, 9'd1,   9'd0,   2'd1, 4, 4, 0, 0, 7);
        run_cmd("single",   9'h055, 9'd0, 9'd0, 9'd1,   9'd0,   2'd3, 0, 0, 2, 3, 3);
        run_cmd("neg_outer",9'h100, 9'd3, 9'd2, 9'd2,   9'h1F0, 2'd2, 0, 0, 3, 0, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
